// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice reused per clock,
// WIDTH+1 cycles per operation under a start/busy/done handshake.
//
// Ports:
//   clk, rst (async, active-high)
//   start, op (0 = a - b, 1 = a + b), a, b    -- request, sampled on clk
//   busy, done                                -- handshake status
//   result, cout, ovf, zero                   -- held until next completion
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_sr;
    logic             op_r;
    logic [CW-1:0]    cnt;
    logic             c;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             a_i;
    logic             b_i;
    logic             sum;
    logic             c_nxt;
    logic             last;
    logic [WIDTH-1:0] next_res;

    // Captured operands stay intact; the current bit is selected by shifting
    // a copy so the index width works for every WIDTH including 1.
    always_comb begin
        a_sh  = a_r >> cnt;
        b_sh  = b_r >> cnt;
        a_i   = a_sh[0];
        b_i   = b_sh[0] ^ ~op_r;
        sum   = a_i ^ b_i ^ c;
        c_nxt = (a_i & b_i) | (a_i & c) | (b_i & c);
        last  = (cnt == CW'(WIDTH - 1));
    end

    // Sum bits enter at the MSB end, so after WIDTH shifts bit 0 sits at LSB.
    generate
        if (WIDTH == 1) begin : g_res1
            assign next_res = sum;
        end else begin : g_resn
            assign next_res = {sum, res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            res_sr <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        cnt   <= '0;
                        // Subtract is a + ~b + 1: the +1 is the initial carry.
                        c     <= ~op;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr <= next_res;
                    c      <= c_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        result <= next_res;
                        // Borrow is the inverted carry of a + ~b + 1.
                        cout   <= op_r ? c_nxt : ~c_nxt;
                        // c is the carry into the MSB on the last bit.
                        ovf    <= c ^ c_nxt;
                        zero   <= (next_res == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        cnt   <= '0;
                        c     <= ~op;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed 4-bit vectors plus
// exhaustive WIDTH=2 and WIDTH=1 instances.
module tb_serial_addsub;

    typedef struct packed {
        logic [3:0] r;
        logic       co;
        logic       ov;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start4 = 1'b0, op4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4, zero4;
    logic [3:0] result4;

    logic       start2 = 1'b0, op2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2, ovf2, zero2;
    logic [1:0] result2;

    logic       start1 = 1'b0, op1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1, zero1;
    logic [0:0] result1;

    int total = 0;
    int bad   = 0;

    exp_t q4[$];
    exp_t q2[$];
    exp_t q1[$];

    logic pd4 = 1'b0, pd2 = 1'b0, pd1 = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4),
        .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    serial_addsub #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2),
        .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    serial_addsub #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1),
        .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    function automatic exp_t mk(int r, bit co, bit ov, bit z);
        exp_t e;
        e.r  = 4'(r);
        e.co = co;
        e.ov = ov;
        e.z  = z;
        return e;
    endfunction

    // Reference: plain integer arithmetic, signs compared for overflow.
    function automatic exp_t model(int w, bit o, int x, int y);
        int  mask;
        int  r;
        bit  co, ov, sa, sb, sr;
        mask = (1 << w) - 1;
        if (o) begin
            r  = (x + y) & mask;
            co = ((x + y) >> w) != 0;
        end else begin
            r  = (x - y) & mask;
            co = x < y;
        end
        sa = ((x >> (w - 1)) & 1) != 0;
        sb = ((y >> (w - 1)) & 1) != 0;
        sr = ((r >> (w - 1)) & 1) != 0;
        if (o) ov = (sa == sb) && (sr != sa);
        else   ov = (sa != sb) && (sr != sa);
        return mk(r, co, ov, r == 0);
    endfunction

    always @(negedge clk) begin
        if (done4) begin
            exp_t e, act;
            act = {result4, cout4, ovf4, zero4};
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL w4_unexpected_done got=%h want=none", act);
            end else begin
                e = q4.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL w4_result got=%h want=%h", act, e);
                end
            end
            total++;
            if (pd4) begin
                bad++;
                $display("FAIL w4_done_twice got=1 want=0");
            end
        end
        pd4 <= done4;
    end

    always @(negedge clk) begin
        if (done2) begin
            exp_t e, act;
            act = {2'b00, result2, cout2, ovf2, zero2};
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL w2_unexpected_done got=%h want=none", act);
            end else begin
                e = q2.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL w2_result got=%h want=%h", act, e);
                end
            end
            total++;
            if (pd2) begin
                bad++;
                $display("FAIL w2_done_twice got=1 want=0");
            end
        end
        pd2 <= done2;
    end

    always @(negedge clk) begin
        if (done1) begin
            exp_t e, act;
            act = {3'b000, result1, cout1, ovf1, zero1};
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL w1_unexpected_done got=%h want=none", act);
            end else begin
                e = q1.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL w1_result got=%h want=%h", act, e);
                end
            end
            total++;
            if (pd1) begin
                bad++;
                $display("FAIL w1_done_twice got=1 want=0");
            end
        end
        pd1 <= done1;
    end

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Entered at the negedge just after the accepting edge (n = 1).
    task automatic wait4(output int n, output int bc);
        n  = 1;
        bc = busy4 ? 1 : 0;
        while (!done4 && n < 30) begin
            @(negedge clk);
            n++;
            if (busy4) bc++;
        end
        if (!done4) begin
            total++;
            bad++;
            $display("FAIL w4_timeout got=no_done want=done");
        end
    endtask

    task automatic go4(bit o, logic [3:0] x, logic [3:0] y, exp_t e);
        int n, bc;
        q4.push_back(e);
        @(negedge clk);
        op4 = o; a4 = x; b4 = y; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait4(n, bc);
        if (done4) begin
            check("w4_latency_edges", n - 1, 4);
            check("w4_busy_cycles", bc, 4);
        end
    endtask

    task automatic run2(bit o, int x, int y);
        int n;
        q2.push_back(model(2, o, x, y));
        @(negedge clk);
        op2 = o; a2 = 2'(x); b2 = 2'(y); start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done2) begin
            total++;
            bad++;
            $display("FAIL w2_timeout got=no_done want=done");
        end
    endtask

    task automatic run1(bit o, int x, int y);
        int n;
        q1.push_back(model(1, o, x, y));
        @(negedge clk);
        op1 = o; a1 = 1'(x); b1 = 1'(y); start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done1) begin
            total++;
            bad++;
            $display("FAIL w1_timeout got=no_done want=done");
        end
    endtask

    initial begin
        int n, bc, dc;

        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({busy4, done4, result4, cout4, ovf4, zero4}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy4), 0);

        go4(1'b0, 4'd5, 4'd3, mk(2, 0, 0, 0));
        go4(1'b0, 4'd3, 4'd5, mk(14, 1, 0, 0));
        go4(1'b0, 4'd8, 4'd1, mk(7, 0, 1, 0));
        go4(1'b1, 4'd7, 4'd1, mk(8, 0, 1, 0));
        go4(1'b1, 4'd15, 4'd1, mk(0, 1, 0, 1));

        // Start during SHIFT must be ignored, operands changed after accept.
        q4.push_back(mk(5, 0, 1, 0));
        @(negedge clk);
        op4 = 1'b0; a4 = 4'd9; b4 = 4'd4; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; op4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4_ignored_start_done", int'(done4), 1);

        // Back-to-back: start held in the DONE cycle.
        q4.push_back(mk(4, 0, 0, 0));
        op4 = 1'b1; a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("w4_b2b_busy", int'(busy4), 1);
        wait4(n, bc);
        if (done4) check("w4_b2b_latency", n - 1, 4);

        // Reset two bits into an operation.
        @(negedge clk);
        op4 = 1'b0; a4 = 4'd7; b4 = 4'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w4_pre_reset_busy", int'(busy4), 1);
        rst = 1'b1;
        #1;
        check("w4_async_reset",
              int'({busy4, done4, result4, cout4, ovf4, zero4}), 0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) dc++;
        end
        check("w4_no_done_after_abort", dc, 0);
        go4(1'b0, 4'd6, 4'd6, mk(0, 0, 0, 1));

        for (int o = 0; o < 2; o++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    run2(o[0], x, y);

        for (int o = 0; o < 2; o++)
            for (int x = 0; x < 2; x++)
                for (int y = 0; y < 2; y++)
                    run1(o[0], x, y);

        repeat (3) @(negedge clk);
        check("queues_drained", q4.size() + q2.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
